// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the accumulation path.
//   EXP_W / MAN_W / FP_W : IEEE-754 single-precision field widths
//   QNAN                 : canonical quiet NaN substituted for a timed-out sum
//   accum_state_t        : fp_accum_seq sequencer states
//   fp_negate            : conditional sign flip applied to incoming operands
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_WAIT,
        ST_OUT
    } accum_state_t;

    // Flip only the sign bit; NaN/inf/zero encodings pass through otherwise untouched.
    function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] x, input logic sub);
        return {x[FP_W-1] ^ sub, x[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fp_accum_wdog.sv
// Watchdog for the adder handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the count from zero
//   en           : count one cycle
//   expire       : count has reached TIMEOUT-1
module fp_accum_wdog
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    assign expire = (count == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fp_accum_seq.sv
// Framed FP32 accumulation sequencer driving an external add/sub unit.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_data/in_sub/in_last        : operand, negate request, end-of-frame marker
//   in_valid/in_ready             : operand handshake
//   add_a/add_b/add_start/add_clr : registered operands and control pulses to the adder
//   add_result/add_done           : adder result and level done
//   out_data/out_count            : frame sum and operand count
//   out_valid/out_ready           : result handshake
//   err                           : sticky adder-timeout flag
// The integration level drives the adder's reset with add_clr | ~reset_n.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_start,
    output logic             add_clr,
    input  logic [31:0]      add_result,
    input  logic             add_done,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    accum_state_t     state_q, state_d;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_q;
    logic [31:0]      operand_b;
    logic             accept;
    logic             idle_ready;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expire;

    assign operand_b = fp_negate(in_data, in_sub);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // State is already IDLE while reset is held, so gate ready with reset_n.
    assign in_ready  = idle_ready & reset_n;
    assign accept    = in_valid & in_ready;

    assign add_clr   = (state_q == ST_CLR);
    assign add_start = (state_q == ST_START);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_count = out_valid ? cnt_q : '0;

    fp_accum_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expire  (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        idle_ready = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        state_d = in_last ? ST_OUT : ST_IDLE;
                    end else begin
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR:   state_d = ST_START;
            ST_START: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                if (add_done) begin
                    state_d = last_q ? ST_OUT : ST_IDLE;
                end else if (wd_expire) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            add_a   <= '0;
            add_b   <= '0;
            last_q  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            acc_q <= operand_b;
                            cnt_q <= CNT_W'(1);
                        end else begin
                            add_a  <= acc_q;
                            add_b  <= operand_b;
                            cnt_q  <= cnt_inc;
                            last_q <= in_last;
                        end
                    end
                end
                ST_WAIT: begin
                    if (add_done) begin
                        acc_q <= add_result;
                    end else if (wd_expire) begin
                        err   <= 1'b1;
                        acc_q <= QNAN;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
module tb_fp_accum_seq;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_sub = 1'b0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_start;
    logic             add_clr;
    logic [31:0]      add_result;
    logic             add_done;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             err;

    always #5 clk = ~clk;

    fp_accum_seq #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sub     (in_sub),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_start  (add_start),
        .add_clr    (add_clr),
        .add_result (add_result),
        .add_done   (add_done),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    // Adder model: known sums for the directed operands.
    function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1 + 2 = 3
            {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000; // 3 + 3 = 6
            {32'h40A0_0000, 32'hC000_0000}: return 32'h4040_0000; // 5 - 2 = 3
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic        mdl_done = 1'b0;
    logic        mdl_busy = 1'b0;
    int          mdl_cnt = 0;
    logic [31:0] mdl_res = '0;
    bit          mdl_hang = 1'b0;
    bit          force_done = 1'b0;
    int          mdl_lat = 3;
    int          n_starts = 0;
    logic [31:0] start_b = '0;

    always @(posedge clk) begin
        if (!reset_n || add_clr) begin
            mdl_done <= 1'b0;
            mdl_busy <= 1'b0;
        end else if (add_start) begin
            mdl_busy <= !mdl_hang;
            mdl_cnt  <= mdl_lat;
            mdl_res  <= fp_add_model(add_a, add_b);
        end else if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                mdl_done <= 1'b1;
                mdl_busy <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (add_start) begin
            n_starts <= n_starts + 1;
            start_b  <= add_b;
        end
    end

    assign add_done   = mdl_done | force_done;
    assign add_result = force_done ? 32'h1234_5678 : mdl_res;

    typedef struct {
        logic [31:0] data;
        logic [31:0] count;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic sub, input logic last);
        int n;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            step();
            n++;
        end
        check("accept_wait", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [31:0] c, input logic e);
        exp_t x;
        x.data  = d;
        x.count = c;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic get_result();
        int   n;
        exp_t x;
        n = 0;
        while (!out_valid && n < 500) begin
            step();
            n++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            check("out_data", out_data, x.data);
            check("out_count", 32'(out_count), x.count);
            check("err", 32'(err), 32'(x.err));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int s0;
        int k;

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_ctrl", {29'd0, add_start, add_clr, err}, 32'd0);
        reset_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Three-element frame 1+2+3
        push_exp(32'h40C0_0000, 32'd3, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b0);
        send(32'h4040_0000, 1'b0, 1'b1);
        get_result();

        // Single element frame: bit-exact, result next cycle, no adder use
        s0 = n_starts;
        push_exp(32'h4049_0FDB, 32'd1, 1'b0);
        send(32'h4049_0FDB, 1'b0, 1'b1);
        check("single_latency", 32'(out_valid), 32'd1);
        get_result();
        check("single_no_start", 32'(n_starts), 32'(s0));

        // Subtract: 5 - 2
        push_exp(32'h4040_0000, 32'd2, 1'b0);
        send(32'h40A0_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b1, 1'b1);
        get_result();
        check("sub_add_b", start_b, 32'hC000_0000);

        // Backpressure: output held, input ignored
        s0 = n_starts;
        push_exp(32'h3F80_0000, 32'd1, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_data", out_data, 32'h3F80_0000);
            check("hold_count", 32'(out_count), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result();
        check("hold_no_start", 32'(n_starts), 32'(s0));

        // Timeout: adder never completes
        mdl_hang = 1'b1;
        push_exp(32'h7FC0_0000, 32'd2, 1'b1);
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        k = 0;
        while (!add_start && k < 20) begin
            step();
            k++;
        end
        check("to_start_seen", 32'(add_start), 32'd1);
        for (int i = 0; i < TIMEOUT; i++) step();
        check("to_not_early_valid", 32'(out_valid), 32'd0);
        check("to_not_early_err", 32'(err), 32'd0);
        step();
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_err", 32'(err), 32'd1);
        get_result();
        mdl_hang = 1'b0;

        // err stays set across a following good frame
        push_exp(32'h4040_0000, 32'd2, 1'b1);
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        get_result();

        // Reset during WAIT, late done ignored
        mdl_hang = 1'b1;
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_add_a", add_a, 32'd0);
        step();
        reset_n = 1'b1;
        mdl_hang = 1'b0;
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("late_done_valid", 32'(out_valid), 32'd0);
            check("late_done_ready", 32'(in_ready), 32'd1);
        end
        force_done = 1'b0;
        push_exp(32'h4049_0FDB, 32'd1, 1'b0);
        send(32'h4049_0FDB, 1'b0, 1'b1);
        get_result();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
